// File: rtl/dvi_timing_gen.sv
// dvi_timing_gen
//   Raster sequencer for the DVI output path, running on the pixel clock.
//   It generates hsync, vsync, DE and the pixel X/Y coordinates, and pulls
//   pixels from an upstream line buffer using a valid/ready handshake.
//   Every output except pix_ready is registered, one clock behind the
//   counters. The block starts and stops only on frame boundaries.
//
// Ports
//   gpu_clk0    in   1   pixel clock (the only clock)
//   Rst         in   1   synchronous reset, active-high
//   enable      in   1   run request; a stop takes effect at the end of the frame
//   pix_valid   in   1   upstream pixel available
//   pix_data    in   24  {red,green,blue} upstream pixel
//   pattern_sel in   1   colour-bar source select (test-pattern build only)
//   pix_ready   out  1   pixel consumed this cycle (combinational from counters)
//   hsync_out   out  1   registered hsync
//   vsync_out   out  1   registered vsync
//   de_out      out  1   registered data enable
//   red_out / green_out / blue_out  out 8 each  registered RGB
//   pix_x       out  12  registered X of the pixel on the outputs
//   pix_y       out  11  registered Y of the pixel on the outputs
//   frame_start out  1   pulse alongside the first pixel of a frame
//   underflow   out  1   pulse: a pixel was due but pix_valid was low
//   running     out  1   high while the sequencer is not idle
//
// Build option
//   DVI_TEST_PATTERN_EN : adds pattern_sel and an internal 8-bar colour pattern.
module dvi_timing_gen #(
  parameter int unsigned H_ACTIVE  = 1280,
  parameter int unsigned H_FP      = 48,
  parameter int unsigned H_SYNC    = 112,
  parameter int unsigned H_BP      = 248,
  parameter int unsigned V_ACTIVE  = 1024,
  parameter int unsigned V_FP      = 1,
  parameter int unsigned V_SYNC    = 3,
  parameter int unsigned V_BP      = 38,
  parameter bit          HSYNC_POL = 1'b1,
  parameter bit          VSYNC_POL = 1'b1
) (
  input  logic        gpu_clk0,
  input  logic        Rst,
  input  logic        enable,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
`ifdef DVI_TEST_PATTERN_EN
  input  logic        pattern_sel,
`endif
  output logic        pix_ready,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  output logic [11:0] pix_x,
  output logic [10:0] pix_y,
  output logic        frame_start,
  output logic        underflow,
  output logic        running
);

  localparam int unsigned H_TOT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_LO = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_HI = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned V_SYNC_LO = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_HI = V_ACTIVE + V_FP + V_SYNC;

  // The coordinate counters are 12/11 bits wide, so totals beyond that cannot wrap correctly.
  if (H_TOT > 4096) begin : g_h_tot_err
    $error("dvi_timing_gen: H_TOT exceeds 4096");
  end
  if (V_TOT > 2048) begin : g_v_tot_err
    $error("dvi_timing_gen: V_TOT exceeds 2048");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t      r_state;
  logic [11:0] r_h_cnt;
  logic [10:0] r_v_cnt;
  logic        r_hsync, r_vsync, r_de, r_frame_start, r_underflow;
  logic [23:0] r_rgb;
  logic [11:0] r_pix_x;
  logic [10:0] r_pix_y;

  logic [31:0] w_h, w_v;
  logic        w_active_st, w_region, w_h_last, w_v_last, w_first;
  logic        w_pattern_now, w_ready, w_hsync_act, w_vsync_act;
  logic [23:0] w_rgb;

  // Counters are zero-extended so every compare against the parameters is unsigned.
  assign w_h         = 32'(r_h_cnt);
  assign w_v         = 32'(r_v_cnt);
  assign w_active_st = (r_state != S_IDLE);
  assign w_region    = w_active_st && (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
  assign w_h_last    = (w_h == H_TOT - 1);
  assign w_v_last    = (w_v == V_TOT - 1);
  assign w_first     = w_active_st && (r_h_cnt == 12'd0) && (r_v_cnt == 11'd0);
  assign w_hsync_act = (w_h >= H_SYNC_LO) && (w_h < H_SYNC_HI);
  assign w_vsync_act = (w_v >= V_SYNC_LO) && (w_v < V_SYNC_HI);

`ifdef DVI_TEST_PATTERN_EN
  logic       r_pattern;
  logic [6:0] w_bar_ge;
  logic [2:0] w_bar_idx;

  // pattern_sel is honoured from the first pixel of the frame it is sampled in.
  assign w_pattern_now = w_first ? pattern_sel : r_pattern;

  // Bar index = number of bar boundaries at or left of the current pixel.
  for (genvar gi = 1; gi < 8; gi++) begin : g_bar
    localparam int unsigned BAR_EDGE = (gi * H_ACTIVE) / 8;
    assign w_bar_ge[gi-1] = (w_h >= BAR_EDGE);
  end

  always_comb begin
    w_bar_idx = 3'd0;
    for (int k = 0; k < 7; k++) begin
      w_bar_idx = w_bar_idx + 3'(w_bar_ge[k]);
    end
  end

  always_ff @(posedge gpu_clk0) begin
    if (Rst) begin
      r_pattern <= 1'b0;
    end else if (w_first) begin
      r_pattern <= pattern_sel;
    end
  end

  always_comb begin
    w_rgb = 24'd0;
    if (w_pattern_now) begin
      if (w_region) begin
        w_rgb = {{8{w_bar_idx[2]}}, {8{w_bar_idx[1]}}, {8{w_bar_idx[0]}}};
      end
    end else if (w_ready && pix_valid) begin
      w_rgb = pix_data;
    end
  end
`else
  assign w_pattern_now = 1'b0;

  always_comb begin
    w_rgb = 24'd0;
    if (w_ready && pix_valid) begin
      w_rgb = pix_data;
    end
  end
`endif

  assign w_ready   = w_region && !w_pattern_now;
  assign pix_ready = w_ready;

  always_ff @(posedge gpu_clk0) begin
    if (Rst) begin
      r_state       <= S_IDLE;
      r_h_cnt       <= 12'd0;
      r_v_cnt       <= 11'd0;
      r_hsync       <= !HSYNC_POL;
      r_vsync       <= !VSYNC_POL;
      r_de          <= 1'b0;
      r_rgb         <= 24'd0;
      r_pix_x       <= 12'd0;
      r_pix_y       <= 11'd0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:  if (enable) r_state <= S_RUN;
        // At the last pixel the enable level decides between wrapping and stopping.
        S_RUN:   if (w_h_last && w_v_last) r_state <= enable ? S_RUN : S_IDLE;
                 else if (!enable)         r_state <= S_DRAIN;
        S_DRAIN: if (w_h_last && w_v_last) r_state <= enable ? S_RUN : S_IDLE;
                 else if (enable)          r_state <= S_RUN;
        default: r_state <= S_IDLE;
      endcase

      // Counters hold at 0,0 while idle, so a restart always begins at the frame origin.
      if (w_active_st) begin
        r_h_cnt <= w_h_last ? 12'd0 : r_h_cnt + 12'd1;
        if (w_h_last) begin
          r_v_cnt <= w_v_last ? 11'd0 : r_v_cnt + 11'd1;
        end
      end

      if (w_active_st) begin
        r_hsync       <= w_hsync_act ? HSYNC_POL : !HSYNC_POL;
        r_vsync       <= w_vsync_act ? VSYNC_POL : !VSYNC_POL;
        r_de          <= w_region;
        r_rgb         <= w_rgb;
        r_pix_x       <= r_h_cnt;
        r_pix_y       <= r_v_cnt;
        r_frame_start <= w_first;
        r_underflow   <= w_ready && !pix_valid;
      end else begin
        r_hsync       <= !HSYNC_POL;
        r_vsync       <= !VSYNC_POL;
        r_de          <= 1'b0;
        r_rgb         <= 24'd0;
        r_pix_x       <= 12'd0;
        r_pix_y       <= 11'd0;
        r_frame_start <= 1'b0;
        r_underflow   <= 1'b0;
      end
    end
  end

  assign hsync_out   = r_hsync;
  assign vsync_out   = r_vsync;
  assign de_out      = r_de;
  assign red_out     = r_rgb[23:16];
  assign green_out   = r_rgb[15:8];
  assign blue_out    = r_rgb[7:0];
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign frame_start = r_frame_start;
  assign underflow   = r_underflow;
  assign running     = w_active_st;

endmodule
